// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction fetch
// port (if_*) and the load/store port (dm_*) of the pipelined core.
// One requester owns the memory at a time and the memory pins are held for
// MEM_LAT cycles per access. Completion is signalled by a one-cycle ready
// pulse with the read data alongside it. The data port has priority. A port
// is masked during its own ready cycle so that a request that is still
// asserted is not granted again, and the other port gets its turn.
//
// Ports
//   CLK, RSTn              clock, synchronous active-low reset
//   if_req/if_addr         fetch request and word address
//   if_rdata/if_ready      fetched word and its completion pulse
//   dm_req/dm_wen/dm_be    data request, 0 = write / 1 = read, byte enables
//   dm_addr/dm_wdata       data address and store data
//   dm_rdata/dm_ready      load data and its completion pulse
//   mem_addr/mem_wen       memory address, active-low write enable
//   mem_be/mem_wdata       memory byte enables and write data
//   mem_rdata              memory read data
//   busy/grant_dm          access in progress / access owned by data port
//   stall_if/stall_mem     pending-request stalls for the control unit

module mem_port_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_wen,
   input  logic [3:0]        dm_be,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_dm,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              ifReady_q, ifReady_d;
   logic              dmReady_q, dmReady_d;
   logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
   logic [DATA_W-1:0] dmRdata_q, dmRdata_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic              memWen_q, memWen_d;
   logic [3:0]        memBe_q, memBe_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;

   // State register. A reset in the middle of an access simply drops it;
   // no ready pulse is produced for the abandoned request.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. In IDLE the data port wins unless it is in its own
   // ready cycle, which is what lets a waiting fetch through when both
   // requests are held. A busy state returns to IDLE once the hold counter
   // has run down to zero.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dm_req && !dmReady_q) begin
               state_d = BUSY_DM;
            end else if (if_req && !ifReady_q) begin
               state_d = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values. On the grant edge the winning port's
   // fields are copied onto the memory pins; fetches are always full-word
   // reads. On the final edge of an access the read data is captured (data
   // port only for loads, so a store leaves dm_rdata alone), the ready pulse
   // is raised, and the pins fall back to their idle write-disabled values
   // while address and write data are left as they were.
   always_comb begin
      cnt_d      = cnt_q;
      ifReady_d  = 1'b0;
      dmReady_d  = 1'b0;
      ifRdata_d  = ifRdata_q;
      dmRdata_d  = dmRdata_q;
      memAddr_d  = memAddr_q;
      memWen_d   = memWen_q;
      memBe_d    = memBe_q;
      memWdata_d = memWdata_q;
      case (state_q)
         IDLE: begin
            if (state_d == BUSY_DM) begin
               memAddr_d  = dm_addr;
               memWen_d   = dm_wen;
               memBe_d    = dm_be;
               memWdata_d = dm_wdata;
               cnt_d      = CNT_LOAD;
            end else if (state_d == BUSY_IF) begin
               memAddr_d  = if_addr;
               memWen_d   = 1'b1;
               memBe_d    = 4'b1111;
               cnt_d      = CNT_LOAD;
            end
         end
         BUSY_IF: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               ifRdata_d = mem_rdata;
               ifReady_d = 1'b1;
               memWen_d  = 1'b1;
               memBe_d   = 4'b0000;
            end
         end
         BUSY_DM: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (memWen_q) begin
                  dmRdata_d = mem_rdata;
               end
               dmReady_d = 1'b1;
               memWen_d  = 1'b1;
               memBe_d   = 4'b0000;
            end
         end
         default: begin
            cnt_d = 4'd0;
         end
      endcase
   end

   // Datapath registers, all cleared to their idle values by reset.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         cnt_q      <= 4'd0;
         ifReady_q  <= 1'b0;
         dmReady_q  <= 1'b0;
         ifRdata_q  <= '0;
         dmRdata_q  <= '0;
         memAddr_q  <= '0;
         memWen_q   <= 1'b1;
         memBe_q    <= 4'b0000;
         memWdata_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         ifReady_q  <= ifReady_d;
         dmReady_q  <= dmReady_d;
         ifRdata_q  <= ifRdata_d;
         dmRdata_q  <= dmRdata_d;
         memAddr_q  <= memAddr_d;
         memWen_q   <= memWen_d;
         memBe_q    <= memBe_d;
         memWdata_q <= memWdata_d;
      end
   end

   // Busy and grant come straight from the state register, and the stalls
   // are held until the matching ready pulse so the pipeline resumes in the
   // same cycle the data becomes valid.
   always_comb begin
      busy      = (state_q != IDLE);
      grant_dm  = (state_q == BUSY_DM);
      stall_if  = if_req & ~ifReady_q;
      stall_mem = dm_req & ~dmReady_q;
   end

   assign if_ready  = ifReady_q;
   assign dm_ready  = dmReady_q;
   assign if_rdata  = ifRdata_q;
   assign dm_rdata  = dmRdata_q;
   assign mem_addr  = memAddr_q;
   assign mem_wen   = memWen_q;
   assign mem_be    = memBe_q;
   assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. A transaction-level model tracks who
// owns the memory and the cycle on which the access was granted, and works
// out every output from cycle arithmetic. It is compared against the DUT on
// every falling edge. Each directed test also checks a few hand-computed
// values at fixed cycle offsets.

module tb_mem_port_arbiter;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 32;
   localparam int MEM_LAT = 2;

   logic              CLK = 1'b0;
   logic              RSTn = 1'b0;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              dm_req;
   logic              dm_wen;
   logic [3:0]        dm_be;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [3:0]        mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              grant_dm;
   logic              stall_if;
   logic              stall_mem;

   int testsRun = 0;
   int testsFailed = 0;
   logic checkEn = 1'b0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .MEM_LAT(MEM_LAT)
   ) dut (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ready (if_ready),
      .dm_req   (dm_req),
      .dm_wen   (dm_wen),
      .dm_be    (dm_be),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .dm_ready (dm_ready),
      .mem_addr (mem_addr),
      .mem_wen  (mem_wen),
      .mem_be   (mem_be),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .grant_dm (grant_dm),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
   );

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s @%0t: actual=%h required=%h", name, $time,
                  actual, expected);
      end
   endtask

   // Drives every requester-side input in one go.
   task automatic applyStimulus(input logic ifReq, input logic [11:0] ifAddr,
                                input logic dmReq, input logic dmWen,
                                input logic [3:0] dmBe, input logic [11:0] dmAddr,
                                input logic [31:0] dmWdata, input logic [31:0] memRdata);
      if_req    = ifReq;
      if_addr   = ifAddr;
      dm_req    = dmReq;
      dm_wen    = dmWen;
      dm_be     = dmBe;
      dm_addr   = dmAddr;
      dm_wdata  = dmWdata;
      mem_rdata = memRdata;
   endtask

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   // Transaction model: owner 0 = none, 1 = fetch, 2 = data. An access
   // granted while idle in cycle g occupies cycles g+1 .. g+MEM_LAT and its
   // ready pulse appears in cycle g+MEM_LAT+1.
   int          mCyc = 0;
   int          mOwner = 0;
   int          mGrantCyc = 0;
   int          mReadyPort = 0;
   logic [11:0] mAddr = '0;
   logic        mWrite = 1'b0;
   logic [3:0]  mBe = '0;
   logic [31:0] mWdata = '0;
   logic [31:0] mIfRdata = '0;
   logic [31:0] mDmRdata = '0;

   always @(negedge CLK) begin
      int nextReady;
      if (checkEn) begin
         checkOutput("m_busy", {31'd0, busy}, {31'd0, mOwner != 0});
         checkOutput("m_grant_dm", {31'd0, grant_dm}, {31'd0, mOwner == 2});
         checkOutput("m_mem_addr", {20'd0, mem_addr}, {20'd0, mAddr});
         checkOutput("m_mem_wen", {31'd0, mem_wen}, {31'd0, !(mOwner == 2 && mWrite)});
         checkOutput("m_mem_be", {28'd0, mem_be}, {28'd0, (mOwner != 0) ? mBe : 4'd0});
         checkOutput("m_mem_wdata", mem_wdata, mWdata);
         checkOutput("m_if_ready", {31'd0, if_ready}, {31'd0, mReadyPort == 1});
         checkOutput("m_dm_ready", {31'd0, dm_ready}, {31'd0, mReadyPort == 2});
         checkOutput("m_if_rdata", if_rdata, mIfRdata);
         checkOutput("m_dm_rdata", dm_rdata, mDmRdata);
         checkOutput("m_stall_if", {31'd0, stall_if}, {31'd0, if_req && mReadyPort != 1});
         checkOutput("m_stall_mem", {31'd0, stall_mem}, {31'd0, dm_req && mReadyPort != 2});
      end
      if (!RSTn) begin
         mOwner = 0; mReadyPort = 0; mAddr = '0; mWrite = 1'b0; mBe = '0;
         mWdata = '0; mIfRdata = '0; mDmRdata = '0;
      end else begin
         nextReady = 0;
         if (mOwner != 0) begin
            if (mCyc == mGrantCyc + MEM_LAT) begin
               nextReady = mOwner;
               if (mOwner == 1) mIfRdata = mem_rdata;
               else if (!mWrite) mDmRdata = mem_rdata;
               mOwner = 0;
            end
         end else if (dm_req && mReadyPort != 2) begin
            mOwner = 2; mGrantCyc = mCyc; mAddr = dm_addr; mWrite = !dm_wen;
            mBe = dm_be; mWdata = dm_wdata;
         end else if (if_req && mReadyPort != 1) begin
            mOwner = 1; mGrantCyc = mCyc; mAddr = if_addr; mWrite = 1'b0;
            mBe = 4'hf;
         end
         mReadyPort = nextReady;
      end
      mCyc++;
   end

   initial begin
      int ifDone;
      int dmDone;
      applyStimulus(0, 12'h0, 0, 1, 4'h0, 12'h0, 32'h0, 32'h0);
      RSTn = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RSTn = 1'b1;
      checkEn = 1'b1;

      // Reset then idle
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         checkOutput("rst_mem_wen", {31'd0, mem_wen}, 32'd1);
         if (c == 9) begin
            checkOutput("rst_busy", {31'd0, busy}, 32'd0);
            checkOutput("rst_if_rdata", if_rdata, 32'd0);
            checkOutput("rst_stall_if", {31'd0, stall_if}, 32'd0);
            checkOutput("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
         end
      end

      // Single fetch
      nextCycle();
      applyStimulus(1, 12'h010, 0, 1, 4'h0, 12'h0, 32'h0, 32'h00A00093);
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         if (c >= 1 && c <= 3) checkOutput("fetch_mem_addr", {20'd0, mem_addr}, 32'h010);
         checkOutput("fetch_if_ready", {31'd0, if_ready}, {31'd0, c == 3});
         checkOutput("fetch_stall_if", {31'd0, stall_if}, {31'd0, c <= 2});
         if (c == 3) checkOutput("fetch_if_rdata", if_rdata, 32'h00A00093);
         nextCycle();
         if (c == 3) if_req = 1'b0;
      end

      // Simultaneous requests
      applyStimulus(1, 12'h044, 1, 1, 4'hf, 12'h020, 32'h0, 32'h11112222);
      for (int c = 0; c < 9; c++) begin
         @(negedge CLK);
         checkOutput("both_grant_dm", {31'd0, grant_dm}, {31'd0, c == 1 || c == 2});
         checkOutput("both_dm_ready", {31'd0, dm_ready}, {31'd0, c == 3});
         checkOutput("both_if_ready", {31'd0, if_ready}, {31'd0, c == 6});
         checkOutput("both_busy", {31'd0, busy},
                     {31'd0, c == 1 || c == 2 || c == 4 || c == 5});
         checkOutput("both_stall_mem", {31'd0, stall_mem}, {31'd0, c <= 2});
         if (c == 4) checkOutput("both_if_addr", {20'd0, mem_addr}, 32'h044);
         nextCycle();
         if (c == 3) dm_req = 1'b0;
         if (c == 6) if_req = 1'b0;
      end

      // Store
      applyStimulus(0, 12'h0, 1, 0, 4'hf, 12'h030, 32'hDEADBEEF, 32'h55555555);
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         checkOutput("store_mem_wen", {31'd0, mem_wen}, {31'd0, !(c == 1 || c == 2)});
         checkOutput("store_dm_ready", {31'd0, dm_ready}, {31'd0, c == 3});
         if (c == 1) begin
            checkOutput("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
            checkOutput("store_mem_addr", {20'd0, mem_addr}, 32'h030);
            checkOutput("store_mem_be", {28'd0, mem_be}, 32'hf);
         end
         if (c == 3) begin
            checkOutput("store_dm_rdata", dm_rdata, 32'h11112222);
            checkOutput("store_be_idle", {28'd0, mem_be}, 32'h0);
         end
         nextCycle();
         if (c == 3) dm_req = 1'b0;
      end

      // Starvation: both held, completions every three cycles alternating
      ifDone = 0;
      dmDone = 0;
      applyStimulus(1, 12'h100, 1, 1, 4'hf, 12'h200, 32'h0, 32'hCAFEF00D);
      for (int c = 0; c < 34; c++) begin
         @(negedge CLK);
         if (if_ready) ifDone++;
         if (dm_ready) dmDone++;
         if (c > 0 && c <= 30 && (c % 3) == 0) begin
            checkOutput("starve_dm_turn", {31'd0, dm_ready}, {31'd0, ((c / 3) % 2) == 1});
            checkOutput("starve_if_turn", {31'd0, if_ready}, {31'd0, ((c / 3) % 2) == 0});
         end
         nextCycle();
         if (c == 29) dm_req = 1'b0;
         if (c == 30) if_req = 1'b0;
      end
      checkOutput("starve_if_count", ifDone, 32'd5);
      checkOutput("starve_dm_count", dmDone, 32'd5);
      checkOutput("starve_total", ifDone + dmDone, 32'd10);

      // Reset in the middle of a store
      applyStimulus(0, 12'h0, 1, 0, 4'h3, 12'h040, 32'h12345678, 32'h0);
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         if (c == 1 || c == 2) checkOutput("rmid_mem_wen_busy", {31'd0, mem_wen}, 32'd0);
         if (c >= 3) checkOutput("rmid_dm_ready", {31'd0, dm_ready}, 32'd0);
         if (c == 3) begin
            checkOutput("rmid_busy", {31'd0, busy}, 32'd0);
            checkOutput("rmid_mem_wen", {31'd0, mem_wen}, 32'd1);
            checkOutput("rmid_if_rdata", if_rdata, 32'd0);
         end
         nextCycle();
         if (c == 1) RSTn = 1'b0;
         if (c == 2) begin
            RSTn = 1'b1;
            dm_req = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
